// File: rtl/spi_reg_bank.sv
// SPI register bank: rxtx data, ctrl, divider and slave-select registers behind a valid/ready port.
// Response is registered one cycle after accept and held until rsp_ready; req_ready is low while a response is pending.
module spi_reg_bank #(
   parameter int REG_WIDTH = 32,
   parameter int ADDR_SIZE = 32,
   parameter int NUM_RXTX  = 4,
   parameter int SS_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_SIZE-1:0]   req_addr,
   input  logic [REG_WIDTH-1:0]   req_wdata,
   input  logic [REG_WIDTH/8-1:0] req_be,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [REG_WIDTH-1:0]   rsp_rdata,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   irq,
   output logic [SS_WIDTH-1:0]    ss_o
);

   localparam int NUM_BYTES = REG_WIDTH / 8;
   localparam logic [ADDR_SIZE-1:0] CTRL_IDX = ADDR_SIZE'(NUM_RXTX);
   localparam logic [ADDR_SIZE-1:0] DIV_IDX  = ADDR_SIZE'(NUM_RXTX + 1);
   localparam logic [ADDR_SIZE-1:0] SS_IDX   = ADDR_SIZE'(NUM_RXTX + 2);
   localparam logic [ADDR_SIZE-1:0] ADDR_END = ADDR_SIZE'(4 * (NUM_RXTX + 3));

   typedef enum logic {IDLE, RESP} state_t;

   state_t                 state_q, state_d;
   logic [REG_WIDTH-1:0]   rxtx_q [NUM_RXTX];
   logic [6:0]             char_len_q;
   logic                   ie_q;
   logic [15:0]            divider_q;
   logic [SS_WIDTH-1:0]    ss_q;
   logic [15:0]            count_q;
   logic                   busy_q;
   logic                   irq_q;
   logic [REG_WIDTH-1:0]   rsp_rdata_q;
   logic                   rsp_err_q;

   logic                   accept;
   logic                   addr_err;
   logic                   wr_en;
   logic                   wr_cfg;
   logic [ADDR_SIZE-1:0]   word_idx;
   logic [REG_WIDTH-1:0]   wmask;
   logic [REG_WIDTH-1:0]   rd_val;
   logic [6:0]             char_len_new;
   logic                   ie_new;
   logic [15:0]            divider_new;
   logic [SS_WIDTH-1:0]    ss_new;

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = !rst;
            accept    = req_valid && !rst;
            if (accept) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      word_idx = req_addr >> 2;
      addr_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_END);
      wr_en    = accept && req_write && !addr_err;
      // ss stays writable during a transfer; everything else is frozen
      wr_cfg   = wr_en && !busy_q;
      for (int b = 0; b < NUM_BYTES; b++) wmask[b*8 +: 8] = {8{req_be[b]}};
      char_len_new = req_be[0] ? req_wdata[6:0] : char_len_q;
      ie_new       = req_be[1] ? req_wdata[9]   : ie_q;
      divider_new  = {req_be[1] ? req_wdata[15:8] : divider_q[15:8],
                      req_be[0] ? req_wdata[7:0]  : divider_q[7:0]};
      for (int b = 0; b < SS_WIDTH; b++) ss_new[b] = req_be[b/8] ? req_wdata[b] : ss_q[b];
   end

   always_comb begin
      rd_val = '0;
      if (!addr_err && !req_write) begin
         for (int i = 0; i < NUM_RXTX; i++)
            if (word_idx == ADDR_SIZE'(i)) rd_val = rxtx_q[i];
         if (word_idx == CTRL_IDX) begin
            rd_val[6:0] = char_len_q;
            rd_val[8]   = busy_q;
            rd_val[9]   = ie_q;
         end
         if (word_idx == DIV_IDX) rd_val[15:0] = divider_q;
         if (word_idx == SS_IDX)  rd_val[SS_WIDTH-1:0] = ss_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < NUM_RXTX; i++) rxtx_q[i] <= '0;
         char_len_q  <= '0;
         ie_q        <= 1'b0;
         divider_q   <= '0;
         ss_q        <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         irq_q       <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= 1'b0;
         // counter loaded with divider, so busy spans divider+1 cycles
         if (busy_q) begin
            if (count_q == 16'd0) begin
               busy_q <= 1'b0;
               irq_q  <= ie_q;
            end else begin
               count_q <= count_q - 16'd1;
            end
         end
         if (wr_cfg) begin
            for (int i = 0; i < NUM_RXTX; i++)
               if (word_idx == ADDR_SIZE'(i))
                  rxtx_q[i] <= (rxtx_q[i] & ~wmask) | (req_wdata & wmask);
            if (word_idx == CTRL_IDX) begin
               char_len_q <= char_len_new;
               ie_q       <= ie_new;
               if (req_be[1] && req_wdata[8]) begin
                  busy_q  <= 1'b1;
                  count_q <= divider_q;
               end
            end
            if (word_idx == DIV_IDX) divider_q <= divider_new;
         end
         if (wr_en && word_idx == SS_IDX) ss_q <= ss_new;
         if (accept) begin
            rsp_rdata_q <= rd_val;
            rsp_err_q   <= addr_err;
         end
      end
   end

   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;
   assign irq       = irq_q;
   assign ss_o      = busy_q ? ss_q : '0;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized bench for spi_reg_bank against a register/timestamp reference model.
module tb_spi_reg_bank;
   localparam int PERIOD = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        irq;
   logic [7:0]  ss_o;

   always #(PERIOD/2) clk = ~clk;

   spi_reg_bank #(.REG_WIDTH(32), .ADDR_SIZE(32), .NUM_RXTX(4), .SS_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .irq(irq), .ss_o(ss_o)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: register contents plus the timestamp of the last transfer start
   logic [31:0] m_rxtx [4];
   logic [6:0]  m_len;
   logic        m_ie;
   logic [15:0] m_div;
   logic [7:0]  m_ss;
   bit          xfer_valid = 1'b0;
   longint      xfer_start = 0;
   longint      xfer_len = 0;
   bit          xfer_ie = 1'b0;
   bit          mon_en = 1'b0;
   int          busy_cnt = 0;
   int          irq_cnt = 0;

   function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
      logic [31:0] r = old_v;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      return r;
   endfunction

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd28);
   endfunction

   // was the timer running during the cycle that ends at edge time t
   function automatic bit busy_before(input longint t);
      longint dt = t - xfer_start;
      return xfer_valid && dt >= PERIOD && dt <= xfer_len * PERIOD;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input bit bsy);
      int idx;
      if (addr_bad(a)) return 32'h0;
      idx = int'(a >> 2);
      if (idx < 4) return m_rxtx[idx];
      if (idx == 4) return {22'b0, m_ie, bsy, 1'b0, m_len};
      if (idx == 5) return {16'b0, m_div};
      return {24'b0, m_ss};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                              input bit bsy, input longint now);
      int idx;
      logic [31:0] tmp;
      if (addr_bad(a)) return;
      idx = int'(a >> 2);
      if (idx == 6) begin
         tmp  = merge_be({24'b0, m_ss}, wd, be);
         m_ss = tmp[7:0];
      end else if (!bsy) begin
         if (idx < 4) m_rxtx[idx] = merge_be(m_rxtx[idx], wd, be);
         else if (idx == 4) begin
            tmp   = merge_be({22'b0, m_ie, 2'b00, m_len}, wd, be);
            m_len = tmp[6:0];
            m_ie  = tmp[9];
            if (be[1] && wd[8]) begin
               xfer_valid = 1'b1;
               xfer_start = now;
               xfer_len   = longint'(m_div) + 1;
               xfer_ie    = m_ie;
            end
         end else begin
            tmp   = merge_be({16'b0, m_div}, wd, be);
            m_div = tmp[15:0];
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_rxtx[i] = '0;
      m_len = '0; m_ie = 1'b0; m_div = '0; m_ss = '0;
      xfer_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      longint dt;
      bit eb, ei;
      if (mon_en) begin
         dt = longint'($time) - xfer_start;
         eb = xfer_valid && dt >= 0 && dt < xfer_len * PERIOD;
         ei = xfer_valid && xfer_ie && dt == xfer_len * PERIOD + PERIOD/2;
         check_eq("busy", busy, eb);
         check_eq("irq", irq, ei);
         check_eq("ss_o", ss_o, eb ? m_ss : 8'h00);
         if (busy) busy_cnt++;
         if (irq) irq_cnt++;
      end
   end

   task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int dly, input bit probe, output logic [31:0] rd, output logic er);
      logic [31:0] exp_rd;
      bit exp_er, bsy;
      int n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (req_ready !== 1'b1) begin
         check_eq("accept_timeout", req_ready, 1'b1);
         req_valid = 1'b0; rd = '0; er = 1'b0;
         return;
      end
      @(posedge clk);
      bsy    = busy_before(longint'($time));
      exp_er = addr_bad(a);
      exp_rd = (w || exp_er) ? 32'h0 : model_read(a, bsy);
      if (w) model_write(a, wd, be, bsy, longint'($time));
      #1 req_valid = 1'b0;
      @(negedge clk);
      check_eq("rsp_latency", rsp_valid, 1'b1);
      for (int i = 0; i < dly; i++) begin
         if (probe) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hC; req_wdata = '1; req_be = '1;
         end
         check_eq("hold_vld", rsp_valid, 1'b1);
         check_eq("hold_rdata", rsp_rdata, exp_rd);
         check_eq("hold_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rd = rsp_rdata; er = rsp_err;
      check_eq("rdata", rd, exp_rd);
      check_eq("err", er, exp_er);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] r;
      logic e;
      do_req(1'b1, a, wd, be, 0, 1'b0, r, e);
   endtask

   task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] r;
      logic e;
      do_req(1'b0, a, 32'h0, 4'h0, 0, 1'b0, r, e);
      check_eq({tag, "_data"}, r, exp_d);
      check_eq({tag, "_err"}, e, exp_e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check_eq("idle_timeout", busy, 1'b0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      check_eq("rst_req_ready", req_ready, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_err", rsp_err, 1'b0);
      check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_irq", irq, 1'b0);
      check_eq("rst_ss_o", ss_o, 8'h00);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_req_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #(PERIOD * 60000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r, a, wd;
      logic e;
      logic [3:0] be;
      int bc0, ic0, sel;

      model_clear();
      do_reset();
      mon_en = 1'b1;

      // byte-enable write and readback
      wr(32'h4, 32'hDEADBEEF, 4'b0101);
      rd_expect("rxtx1_be", 32'h4, 32'h00AD00EF, 1'b0);

      // address errors leave state untouched
      rd_expect("err_1c", 32'h1C, 32'h0, 1'b1);
      rd_expect("err_unal", 32'h2, 32'h0, 1'b1);
      wr(32'h1C, 32'hFFFFFFFF, 4'hF);
      wr(32'h6, 32'hFFFFFFFF, 4'hF);
      rd_expect("rxtx1_keep", 32'h4, 32'h00AD00EF, 1'b0);
      rd_expect("ss_keep", 32'h18, 32'h0, 1'b0);

      // reserved bits read as zero
      wr(32'h10, 32'hFFFFFEFF, 4'hF);
      rd_expect("ctrl_mask", 32'h10, 32'h0000027F, 1'b0);
      wr(32'h14, 32'hFFFF0002, 4'hF);
      rd_expect("div_mask", 32'h14, 32'h00000002, 1'b0);
      wr(32'h18, 32'hFFFFFFFF, 4'h0);
      rd_expect("be_zero_noop", 32'h18, 32'h0, 1'b0);

      // divider=3 transfer with interrupt enabled
      wr(32'h14, 32'h3, 4'hF);
      wr(32'h18, 32'h5, 4'hF);
      bc0 = busy_cnt; ic0 = irq_cnt;
      wr(32'h10, 32'h300, 4'h3);
      check_eq("ss_o_during", ss_o, 8'h05);
      wait_idle();
      check_eq("busy_cycles", busy_cnt - bc0, 4);
      check_eq("irq_cycles", irq_cnt - ic0, 1);
      rd_expect("ctrl_done", 32'h10, 32'h200, 1'b0);

      // write protection while busy, ss still writable, GO_BSY=0 does not abort
      wr(32'h0, 32'hA5A5A5A5, 4'hF);
      wr(32'h14, 32'd20, 4'hF);
      wr(32'h10, 32'h100, 4'h3);
      do_req(1'b1, 32'h0, 32'h1234, 4'hF, 0, 1'b0, r, e);
      check_eq("prot_wr_err", e, 1'b0);
      rd_expect("rxtx0_prot", 32'h0, 32'hA5A5A5A5, 1'b0);
      wr(32'h18, 32'h2, 4'h1);
      check_eq("ss_o_new", ss_o, 8'h02);
      wr(32'h10, 32'h0, 4'h3);
      check_eq("no_abort", busy, 1'b1);
      wait_idle();

      // response backpressure with a competing request
      wr(32'h8, 32'hCAFEF00D, 4'hF);
      do_req(1'b0, 32'h8, 32'h0, 4'h0, 5, 1'b1, r, e);
      check_eq("stall_rdata", r, 32'hCAFEF00D);
      rd_expect("probe_blocked", 32'hC, 32'h0, 1'b0);

      for (int it = 0; it < 250; it++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 6) a = 32'(4 * sel);
         else if (sel == 7) a = $urandom_range(0, 31);
         else if (sel == 8) a = 32'h1C + 32'(4 * $urandom_range(0, 4));
         else a = 32'(4 * $urandom_range(0, 6) + $urandom_range(1, 3));
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         if (a == 32'h14) wd[15:0] = 16'($urandom_range(0, 6));
         do_req(1'($urandom_range(0, 1)), a, wd, be, $urandom_range(0, 3), 1'b0, r, e);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_idle();

      // reset in the middle of a transfer
      wr(32'h14, 32'd30, 4'hF);
      wr(32'h0, 32'h11223344, 4'hF);
      wr(32'h18, 32'h81, 4'hF);
      wr(32'h10, 32'h300, 4'h3);
      ic0 = irq_cnt;
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 7; i++) rd_expect("post_rst_reg", 32'(4 * i), 32'h0, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      check_eq("no_irq_after_rst", irq_cnt - ic0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
